// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: latches and decodes each instruction, then sequences
// FETCH/DECODE/EXEC/MEM/MEMWB/WB while driving the datapath control lines.
module multicycle_control #(
  parameter int CW              = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instruction,
  input  logic          zero,
  input  logic          stall,
  output logic          branch,
  output logic          mem2reg,
  output logic          memwrite,
  output logic          alusrc,
  output logic          regwrite,
  output logic          pcsrc,
  output logic [3:0]    aluctl,
  output logic          pc_write,
  output logic          ir_write,
  output logic [2:0]    state,
  output logic [CW-1:0] instret,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_MEMWB  = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_ADDI, C_LW, C_SW, C_BEQ, C_ILL
  } cls_t;

  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [CW-1:0] instret_q, instret_d;
  logic          illegal_q, illegal_d;
  cls_t          cls;

  logic br_raw, m2r_raw, mw_raw, src_raw, rw_raw, pcw_raw, irw_raw;
  logic [3:0] alu_raw;

  function automatic cls_t classify(input logic [31:0] ir);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ir[6:0];
    f3 = ir[14:12];
    f7 = ir[31:25];
    classify = C_ILL;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  classify = C_ADD;
            3'b111:  classify = C_AND;
            3'b110:  classify = C_OR;
            3'b010:  classify = C_SLT;
            default: classify = C_ILL;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          classify = C_SUB;
        end
      end
      7'b0010011: if (f3 == 3'b000) classify = C_ADDI;
      7'b0000011: if (f3 == 3'b010) classify = C_LW;
      7'b0100011: if (f3 == 3'b010) classify = C_SW;
      7'b1100011: if (f3 == 3'b000) classify = C_BEQ;
      default:    classify = C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] alu_of(input cls_t c);
    case (c)
      C_SUB, C_BEQ: alu_of = 4'b0110;
      C_AND:        alu_of = 4'b0000;
      C_OR:         alu_of = 4'b0001;
      C_SLT:        alu_of = 4'b0111;
      default:      alu_of = 4'b0010;
    endcase
  endfunction

  function automatic logic uses_imm(input cls_t c);
    uses_imm = (c == C_ADDI) || (c == C_LW) || (c == C_SW);
  endfunction

  assign cls = classify(ir_q);

  // Moore decode of state + latched instruction, before stall/reset gating
  always_comb begin
    br_raw  = 1'b0;
    m2r_raw = 1'b0;
    mw_raw  = 1'b0;
    src_raw = 1'b0;
    rw_raw  = 1'b0;
    pcw_raw = 1'b0;
    irw_raw = 1'b0;
    alu_raw = 4'b0000;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        irw_raw = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls == C_ILL) begin
          pcw_raw = !HALT_ON_ILLEGAL;
          state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        src_raw = uses_imm(cls);
        alu_raw = alu_of(cls);
        if (cls == C_BEQ) begin
          br_raw  = 1'b1;
          pcw_raw = 1'b1;
          state_d = S_FETCH;
        end else if (cls == C_LW || cls == C_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        src_raw = 1'b1;
        alu_raw = 4'b0010;
        if (cls == C_SW) begin
          mw_raw  = 1'b1;
          pcw_raw = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        src_raw = 1'b1;
        alu_raw = 4'b0010;
        m2r_raw = 1'b1;
        rw_raw  = 1'b1;
        pcw_raw = 1'b1;
        state_d = S_FETCH;
      end
      S_WB: begin
        src_raw = uses_imm(cls);
        alu_raw = alu_of(cls);
        rw_raw  = 1'b1;
        pcw_raw = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_d      = (state_q == S_FETCH) ? instruction : ir_q;
    instret_d = pcw_raw ? instret_q + CW'(1) : instret_q;
    illegal_d = illegal_q | ((state_q == S_DECODE) && (cls == C_ILL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      ir_q      <= 32'd0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else if (!stall) begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are suppressed while stalled or in reset; mux selects are not
  assign regwrite = rw_raw  & ~stall & ~rst;
  assign memwrite = mw_raw  & ~stall & ~rst;
  assign pc_write = pcw_raw & ~stall & ~rst;
  assign ir_write = irw_raw & ~stall & ~rst;
  assign branch   = br_raw;
  assign mem2reg  = m2r_raw;
  assign alusrc   = src_raw;
  assign aluctl   = alu_raw;
  assign pcsrc    = br_raw & zero;
  assign state    = state_q;
  assign instret  = instret_q;
  assign halted   = (state_q == S_HALT);
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus hand-written
// sequences for HALT hold, non-halting illegal handling and counter wrap.
module tb_multicycle_control;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h00502623;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0;
  logic        stall = 1'b0;

  logic a_branch, a_mem2reg, a_memwrite, a_alusrc, a_regwrite, a_pcsrc, a_pc_write, a_ir_write;
  logic a_halted, a_illegal;
  logic [3:0]  a_aluctl;
  logic [2:0]  a_state;
  logic [31:0] a_instret;

  logic b_branch, b_mem2reg, b_memwrite, b_alusrc, b_regwrite, b_pcsrc, b_pc_write, b_ir_write;
  logic b_halted, b_illegal;
  logic [3:0] b_aluctl;
  logic [2:0] b_state;
  logic [3:0] b_instret;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CW(32), .HALT_ON_ILLEGAL(1'b1)) u_halt (
    .clk(clk), .rst(rst), .instruction(instr), .zero(zero), .stall(stall),
    .branch(a_branch), .mem2reg(a_mem2reg), .memwrite(a_memwrite), .alusrc(a_alusrc),
    .regwrite(a_regwrite), .pcsrc(a_pcsrc), .aluctl(a_aluctl), .pc_write(a_pc_write),
    .ir_write(a_ir_write), .state(a_state), .instret(a_instret), .halted(a_halted),
    .illegal(a_illegal)
  );

  multicycle_control #(.CW(4), .HALT_ON_ILLEGAL(1'b0)) u_skip (
    .clk(clk), .rst(rst), .instruction(instr), .zero(zero), .stall(stall),
    .branch(b_branch), .mem2reg(b_mem2reg), .memwrite(b_memwrite), .alusrc(b_alusrc),
    .regwrite(b_regwrite), .pcsrc(b_pcsrc), .aluctl(b_aluctl), .pc_write(b_pc_write),
    .ir_write(b_ir_write), .state(b_state), .instret(b_instret), .halted(b_halted),
    .illegal(b_illegal)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic        zero;
    logic [31:0] instr;
    logic [2:0]  st;
    logic [7:0]  ctl;
    logic [3:0]  alu;
    logic [31:0] cnt;
    logic [1:0]  hi;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic s, input logic z, input logic [31:0] i,
                              input logic [2:0] st, input logic [7:0] ctl, input logic [3:0] alu,
                              input logic [31:0] cnt, input logic [1:0] hi);
    vec_t v;
    v.rst = r; v.stall = s; v.zero = z; v.instr = i;
    v.st = st; v.ctl = ctl; v.alu = alu; v.cnt = cnt; v.hi = hi;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic z, input logic [31:0] i);
    @(posedge clk);
    #1;
    rst = r; stall = s; zero = z; instr = i;
    @(negedge clk);
  endtask

  logic [7:0] a_ctl;
  assign a_ctl = {a_branch, a_mem2reg, a_memwrite, a_alusrc, a_regwrite, a_pcsrc, a_pc_write, a_ir_write};

  initial begin
    // ctl bits: {branch, mem2reg, memwrite, alusrc, regwrite, pcsrc, pc_write, ir_write}
    tbl.push_back(mk(1,0,0,I_ADD,  0,8'b00000000,4'b0000,0,2'b00));
    tbl.push_back(mk(0,0,0,I_ADD,  0,8'b00000001,4'b0000,0,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  1,8'b00000000,4'b0000,0,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  2,8'b00000000,4'b0010,0,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  5,8'b00001010,4'b0010,0,2'b00));
    tbl.push_back(mk(0,0,0,I_LW,   0,8'b00000001,4'b0000,1,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  1,8'b00000000,4'b0000,1,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  2,8'b00010000,4'b0010,1,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  3,8'b00010000,4'b0010,1,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  4,8'b01011010,4'b0010,1,2'b00));
    tbl.push_back(mk(0,0,0,I_SW,   0,8'b00000001,4'b0000,2,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  1,8'b00000000,4'b0000,2,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  2,8'b00010000,4'b0010,2,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  3,8'b00110010,4'b0010,2,2'b00));
    tbl.push_back(mk(0,0,1,I_BEQ,  0,8'b00000001,4'b0000,3,2'b00));
    tbl.push_back(mk(0,0,1,32'd0,  1,8'b00000000,4'b0000,3,2'b00));
    tbl.push_back(mk(0,0,1,32'd0,  2,8'b10000110,4'b0110,3,2'b00));
    tbl.push_back(mk(0,0,0,I_BEQ,  0,8'b00000001,4'b0000,4,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  1,8'b00000000,4'b0000,4,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  2,8'b10000010,4'b0110,4,2'b00));
    tbl.push_back(mk(0,0,0,I_ADDI, 0,8'b00000001,4'b0000,5,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  1,8'b00000000,4'b0000,5,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  2,8'b00010000,4'b0010,5,2'b00));
    tbl.push_back(mk(0,1,0,32'd0,  5,8'b00010000,4'b0010,5,2'b00));
    tbl.push_back(mk(0,1,0,32'd0,  5,8'b00010000,4'b0010,5,2'b00));
    tbl.push_back(mk(0,1,0,32'd0,  5,8'b00010000,4'b0010,5,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  5,8'b00011010,4'b0010,5,2'b00));
    tbl.push_back(mk(0,1,0,I_SW,   0,8'b00000000,4'b0000,6,2'b00));
    tbl.push_back(mk(0,0,0,I_SW,   0,8'b00000001,4'b0000,6,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  1,8'b00000000,4'b0000,6,2'b00));
    tbl.push_back(mk(0,0,0,32'd0,  2,8'b00010000,4'b0010,6,2'b00));
    tbl.push_back(mk(1,0,0,32'd0,  0,8'b00000000,4'b0000,0,2'b00));
    tbl.push_back(mk(0,0,0,I_ILL,  0,8'b00000001,4'b0000,0,2'b00));
    tbl.push_back(mk(0,0,0,I_ILL,  1,8'b00000000,4'b0000,0,2'b00));
    tbl.push_back(mk(0,0,0,I_ADD,  7,8'b00000000,4'b0000,0,2'b11));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].zero, tbl[i].instr);
      chk($sformatf("row%0d", i),
          {13'd0, a_state, a_ctl, a_aluctl, a_instret, a_halted, a_illegal},
          {13'd0, tbl[i].st, tbl[i].ctl, tbl[i].alu, tbl[i].cnt, tbl[i].hi});
    end

    // HALT is sticky: nothing fires for 20 cycles despite legal input
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 1, I_ADD);
      chk($sformatf("halt_hold%0d", k), {51'd0, a_state, a_ctl, a_halted, a_illegal},
          {51'd0, 3'd7, 8'd0, 2'b11});
    end

    // Non-halting illegal: skip as a retired NOP
    drive(1, 0, 0, I_ILL);
    drive(0, 0, 0, I_ILL);
    chk("skip_fetch_irw", {62'd0, b_ir_write, b_state == 3'd0}, {62'd0, 2'b11});
    drive(0, 0, 0, 32'd0);
    chk("skip_decode_pcw", {57'd0, b_state, b_pc_write, a_pc_write}, {57'd0, 3'd1, 2'b10});
    drive(0, 0, 0, 32'd0);
    chk("skip_after", {55'd0, b_state, b_instret, b_illegal, b_halted},
        {55'd0, 3'd0, 4'd1, 2'b10});
    chk("halt_after", {60'd0, a_state, a_halted}, {60'd0, 3'd7, 1'b1});

    // 16 back-to-back beq retires wrap the 4-bit counter
    drive(1, 0, 0, I_BEQ);
    for (int k = 1; k <= 49; k++) begin
      drive(0, 0, 0, I_BEQ);
      if (k == 46) chk("wrap_pre", {60'd0, b_instret}, {60'd0, 4'd15});
      if (k == 49) begin
        chk("wrap_cw4", {57'd0, b_state, b_instret}, {57'd0, 3'd0, 4'd0});
        chk("count_cw32", {32'd0, a_instret}, {32'd0, 32'd16});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
